// File: rtl/com_pkg.sv
// Shared types and constants for the com transmit/receive blocks.
package com_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SEND,
    ST_DONE,
    ST_RELEASE
  } tx_arb_state_e;

  localparam int DLEN_W_DEF  = 13;
  localparam int BTYPE_W_DEF = 4;

  // Packet types understood by both the transmit controller and the receive parser.
  localparam logic [3:0] PT_NONE       = 4'h0;
  localparam logic [3:0] PT_ACQ_DATA   = 4'h1;
  localparam logic [3:0] PT_CACHE_DATA = 4'h2;
  localparam logic [3:0] PT_STATUS     = 4'h3;
  localparam logic [3:0] PT_CMD_ACK    = 4'h4;
  localparam logic [3:0] PT_HEARTBEAT  = 4'h5;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/com_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr_i, modulo N.
module com_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset back to ptr_i so the nearest hit is written last.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    sum     = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(N - 1 - k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      cand = IDX_W'(sum);
      if (|(req_i & (N'(1) << cand))) begin
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/com_tx_arb.sv
// Round-robin arbiter sharing the Ethernet transmit path between NUM_REQ producers.
// Optional downstream watchdog enabled by defining COM_TX_ARB_TIMEOUT_EN.
module com_tx_arb
  import com_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DLEN_W      = DLEN_W_DEF,
  parameter int BTYPE_W     = BTYPE_W_DEF,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         fs_req,
  output logic [NUM_REQ-1:0]         fd_req,
  input  logic [NUM_REQ*BTYPE_W-1:0] req_btype,
  input  logic [NUM_REQ*DLEN_W-1:0]  req_dlen,
  output logic                       fs_send,
  input  logic                       fd_send,
  output logic [BTYPE_W-1:0]         btype,
  output logic [IDX_W-1:0]           didx,
  output logic [DLEN_W-1:0]          dlen,
  output logic                       busy,
  output logic                       err
);

  if ((NUM_REQ < 2) || (NUM_REQ > 8) || ((1 << IDX_W) < NUM_REQ) || (TIMEOUT_CYC < 2)) begin : g_param_check
    $error("com_tx_arb: illegal parameter combination");
  end

  tx_arb_state_e        state_q, state_d;
  logic [NUM_REQ-1:0]   fd_req_q, fd_req_d;
  logic                 fs_send_q, fs_send_d;
  logic [BTYPE_W-1:0]   btype_q, btype_d;
  logic [IDX_W-1:0]     didx_q, didx_d;
  logic [DLEN_W-1:0]    dlen_q, dlen_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [BTYPE_W-1:0]   pick_btype;
  logic [DLEN_W-1:0]    pick_dlen;
  logic [NUM_REQ-1:0]   grant_oh;
  logic                 owner_req;

`ifdef COM_TX_ARB_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  com_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (fs_req),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    pick_btype = '0;
    pick_dlen  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == pick_idx) begin
        pick_btype = req_btype[k*BTYPE_W +: BTYPE_W];
        pick_dlen  = req_dlen[k*DLEN_W +: DLEN_W];
      end
    end
  end

  assign grant_oh  = NUM_REQ'(1) << didx_q;
  assign owner_req = |(fs_req & grant_oh);

  always_comb begin
    state_d   = state_q;
    fd_req_d  = fd_req_q;
    fs_send_d = fs_send_q;
    btype_d   = btype_q;
    didx_d    = didx_q;
    dlen_d    = dlen_q;
    rr_ptr_d  = rr_ptr_q;
`ifdef COM_TX_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          didx_d  = pick_idx;
          btype_d = pick_btype;
          dlen_d  = pick_dlen;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (dlen_q == '0) begin
          state_d = ST_DONE;
        end else begin
          fs_send_d = 1'b1;
          state_d   = ST_SEND;
`ifdef COM_TX_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ST_SEND: begin
        // A returning fd_send takes precedence over an expiring watchdog.
        if (fd_send) begin
          fs_send_d = 1'b0;
          state_d   = ST_DONE;
        end
`ifdef COM_TX_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          fs_send_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      ST_DONE: begin
        fd_req_d = grant_oh;
        state_d  = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!owner_req) begin
          fd_req_d = '0;
          rr_ptr_d = IDX_W'(rr_next(32'(didx_q), NUM_REQ));
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fd_req_q  <= '0;
      fs_send_q <= 1'b0;
      btype_q   <= '0;
      didx_q    <= '0;
      dlen_q    <= '0;
      rr_ptr_q  <= '0;
`ifdef COM_TX_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      fd_req_q  <= fd_req_d;
      fs_send_q <= fs_send_d;
      btype_q   <= btype_d;
      didx_q    <= didx_d;
      dlen_q    <= dlen_d;
      rr_ptr_q  <= rr_ptr_d;
`ifdef COM_TX_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign fd_req  = fd_req_q;
  assign fs_send = fs_send_q;
  assign btype   = btype_q;
  assign didx    = didx_q;
  assign dlen    = dlen_q;
  assign busy    = (state_q != ST_IDLE);
`ifdef COM_TX_ARB_TIMEOUT_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule
